// File: rtl/gf_pkg.sv
// gf_pkg: shared types and constants for the GF(2^M) inverter family.
//   gf_state_e   : sequencer states (IDLE, CALC, DONE)
//   GF_M         : default field width (AES field)
//   GF_POLY_AES  : x^8+x^4+x^3+x+1
//   GF_POLY_M4   : x^4+x+1, for subfield studies
package gf_pkg;

  localparam int         GF_M        = 8;
  localparam logic [8:0] GF_POLY_AES = 9'h11B;
  localparam logic [4:0] GF_POLY_M4  = 5'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gf_state_e;

endpackage

// File: rtl/gf_mul.sv
// gf_mul: combinational GF(2^M) multiplier, polynomial basis, reduced modulo POLY.
// Ports:
//   a_i [M-1:0]  multiplicand
//   b_i [M-1:0]  multiplier
//   p_o [M-1:0]  a*b mod POLY
// Parameters:
//   M     field width (2..16)
//   POLY  irreducible polynomial, M+1 bits, bit M set
module gf_mul #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = (M+1)'(9'h11B)
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [M-1:0] p_o
);

  logic [M-1:0] prod;
  logic [M-1:0] shf;

  // Shift-and-add: shf walks a*x^i (already reduced), added in where b has a 1.
  // Reduction only needs the low M bits of POLY since x^M is implied by the carry-out.
  always_comb begin
    prod = '0;
    shf  = a_i;
    for (int i = 0; i < M; i++) begin
      if (b_i[i]) prod = prod ^ shf;
      shf = shf[M-1] ? ((shf << 1) ^ POLY[M-1:0]) : (shf << 1);
    end
  end

  assign p_o = prod;

endmodule

// File: rtl/gf_inv_seq.sv
// gf_inv_seq: multi-cycle GF(2^M) inverter, out = a^(2^M-2) (0 for a=0).
// One square-and-multiply step per cycle, M-1 steps per operand.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand, in_ready_o high
// CALC  | sq <- sq^2, acc <- acc*sq^2, M-1 steps
// DONE  | result held on out_data_o until out_valid_o && out_ready_i
//
// Ports:
//   clk_sys_i           clock
//   rst_b_i             synchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i [M-1:0]     operand handshake
//   out_valid_o/out_ready_i/out_data_o [M-1:0]  result handshake
//   out_zero_o          only with GF_INV_ZERO_FLAG_EN: accepted operand was 0
//
// Build option: define GF_INV_ZERO_FLAG_EN to add out_zero_o.
module gf_inv_seq
  import gf_pkg::*;
#(
  parameter int         M    = GF_M,
  parameter logic [M:0] POLY = (M+1)'(GF_POLY_AES)
) (
  input  logic         clk_sys_i,
  input  logic         rst_b_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [M-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [M-1:0] out_data_o
`ifdef GF_INV_ZERO_FLAG_EN
  ,
  output logic         out_zero_o
`endif
);

  localparam int CW = (M > 2) ? $clog2(M) : 1;

  gf_state_e     state_q, state_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [M-1:0]  sq_q, sq_d;
  logic [M-1:0]  out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovld_q, ovld_d;
  logic [M-1:0]  s2;
  logic [M-1:0]  acc_mul;
`ifdef GF_INV_ZERO_FLAG_EN
  logic          zero_q, zero_d;
`endif

  gf_mul #(.M(M), .POLY(POLY)) u_sq_mul (
    .a_i (sq_q),
    .b_i (sq_q),
    .p_o (s2)
  );

  gf_mul #(.M(M), .POLY(POLY)) u_acc_mul (
    .a_i (acc_q),
    .b_i (s2),
    .p_o (acc_mul)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    ovld_d  = ovld_q;
`ifdef GF_INV_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sq_d    = in_data_i;
          acc_d   = M'(1);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sq_d  = s2;
        acc_d = acc_mul;
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(M - 2)) begin
          out_d   = acc_mul;
          ovld_d  = 1'b1;
          state_d = DONE;
`ifdef GF_INV_ZERO_FLAG_EN
          // In a field the only element without an inverse is 0, so a zero
          // product identifies a zero operand.
          zero_d  = (acc_mul == '0);
`endif
        end
      end
      DONE: begin
        if (out_ready_i) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_b_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sq_q    <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      ovld_q  <= 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ovld_q  <= ovld_d;
`ifdef GF_INV_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  // Gated by reset so nothing is accepted while reset is asserted.
  assign in_ready_o  = (state_q == IDLE) && rst_b_i;
  assign out_valid_o = ovld_q;
  assign out_data_o  = out_q;
`ifdef GF_INV_ZERO_FLAG_EN
  assign out_zero_o  = zero_q;
`else
  // Zero flag not built; the result alone (0 for a=0) carries that information.
`endif

endmodule

// File: tb/tb_gf_inv_seq.sv
// tb_gf_inv_seq: self-checking bench for gf_inv_seq, M=8 (AES) and M=4 (x^4+x+1).
module tb_gf_inv_seq;
  import gf_pkg::*;

  logic       clk_sys = 1'b0;
  logic       rst_b;
  logic       iv8, ir8, ov8, or8;
  logic [7:0] id8, od8;
  logic       iv4, ir4, ov4, or4;
  logic [3:0] id4, od4;
`ifdef GF_INV_ZERO_FLAG_EN
  logic       oz8, oz4;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  gf_inv_seq #(.M(8), .POLY(GF_POLY_AES)) dut8 (
    .clk_sys_i   (clk_sys),
    .rst_b_i     (rst_b),
    .in_valid_i  (iv8),
    .in_ready_o  (ir8),
    .in_data_i   (id8),
    .out_valid_o (ov8),
    .out_ready_i (or8),
    .out_data_o  (od8)
`ifdef GF_INV_ZERO_FLAG_EN
    ,
    .out_zero_o  (oz8)
`endif
  );

  gf_inv_seq #(.M(4), .POLY(GF_POLY_M4)) dut4 (
    .clk_sys_i   (clk_sys),
    .rst_b_i     (rst_b),
    .in_valid_i  (iv4),
    .in_ready_o  (ir4),
    .in_data_i   (id4),
    .out_valid_o (ov4),
    .out_ready_i (or4),
    .out_data_o  (od4)
`ifdef GF_INV_ZERO_FLAG_EN
    ,
    .out_zero_o  (oz4)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference arithmetic: schoolbook carry-less multiply with reduction by the
  // full polynomial, and inversion by exhaustive search for b with a*b = 1.
  function automatic int fmul(input int a, input int b, input int m, input int poly);
    int p = 0;
    int x = a;
    for (int i = 0; i < m; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x[m]) x = x ^ poly;
    end
    return p;
  endfunction

  function automatic int finv(input int a, input int m, input int poly);
    if (a == 0) return 0;
    for (int b = 1; b < (1 << m); b++)
      if (fmul(a, b, m, poly) == 1) return b;
    return -1;
  endfunction

  function automatic int rdy(input bit u);   return u ? int'(ir4) : int'(ir8); endfunction
  function automatic int ovld(input bit u);  return u ? int'(ov4) : int'(ov8); endfunction
  function automatic int odata(input bit u); return u ? int'(od4) : int'(od8); endfunction
`ifdef GF_INV_ZERO_FLAG_EN
  function automatic int zflag(input bit u); return u ? int'(oz4) : int'(oz8); endfunction
`endif

  task automatic set_in(input bit u, input bit v, input int d);
    if (u) begin iv4 = v; id4 = d[3:0]; end
    else   begin iv8 = v; id8 = d[7:0]; end
  endtask

  task automatic set_ordy(input bit u, input bit v);
    if (u) or4 = v; else or8 = v;
  endtask

  // Called and returns at a negedge. lat = edges from input handshake to out_valid.
  task automatic do_op(input bit u, input int a, input int stall, output int r, output int lat);
    int g;
    set_ordy(u, stall == 0);
    set_in(u, 1'b1, a);
    g = 0;
    while (rdy(u) == 0 && g < 50) begin @(negedge clk_sys); g++; end
    if (g >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk_sys); @(negedge clk_sys);
    set_in(u, 1'b0, a);
    lat = 0;
    while (ovld(u) == 0 && lat < 100) begin @(negedge clk_sys); lat++; end
    if (lat >= 100) chk("result_timeout", 0, 1);
    r = odata(u);
`ifdef GF_INV_ZERO_FLAG_EN
    chk("out_zero", zflag(u), (a == 0) ? 1 : 0);
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_sys);
      chk("stall_hold", odata(u), r);
      chk("stall_valid", ovld(u), 1);
    end
    set_ordy(u, 1'b1);
    @(posedge clk_sys); @(negedge clk_sys);
    chk("valid_drop", ovld(u), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r, lat, nres, vcnt;
    int sw_a[3];
    int sw_e[3];
    int res_w[2];
    int res_d[2];
    sw_a = '{0, 1, 2};
    sw_e = '{0, 1, 'h8D};

    rst_b = 1'b0;
    iv8 = 1'b0; id8 = '0; or8 = 1'b0;
    iv4 = 1'b0; id4 = '0; or4 = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_in_ready8", int'(ir8), 0);
    chk("rst_out_valid8", int'(ov8), 0);
    chk("rst_out_data8", int'(od8), 0);
    chk("rst_in_ready4", int'(ir4), 0);
    rst_b = 1'b1;
    #1;
    chk("post_rst_in_ready8", int'(ir8), 1);
    @(negedge clk_sys);

    // Known AES vector and latency
    do_op(1'b0, 'h53, 0, r, lat);
    chk("inv_53", r, 'hCA);
    chk("lat_53", lat, 7);

    foreach (sw_a[i]) begin
      do_op(1'b0, sw_a[i], 0, r, lat);
      chk("sweep", r, sw_e[i]);
      chk("sweep_lat", lat, 7);
    end

    // Every nonzero element of GF(2^8)
    for (int a = 1; a < 256; a++) begin
      do_op(1'b0, a, 0, r, lat);
      chk("inv8_ref", r, finv(a, 8, 'h11B));
      chk("inv8_prod", fmul(a, r, 8, 'h11B), 1);
    end

    // Random operands with random downstream stalls
    for (int k = 0; k < 40; k++) begin
      int a, st;
      a  = int'($urandom_range(0, 255));
      st = int'($urandom_range(0, 4));
      do_op(1'b0, a, st, r, lat);
      chk("rand_inv8", r, finv(a, 8, 'h11B));
      chk("rand_lat8", lat, 7);
    end

    // M=4 subfield
    do_op(1'b1, 'h2, 0, r, lat);
    chk("inv4_2", r, 'h9);
    chk("lat4", lat, 3);
    do_op(1'b1, 'hF, 0, r, lat);
    chk("inv4_F", r, 'h8);
    for (int a = 0; a < 16; a++) begin
      do_op(1'b1, a, int'($urandom_range(0, 2)), r, lat);
      chk("inv4_ref", r, finv(a, 4, 'h13));
      chk("lat4_all", lat, 3);
    end

    // Backpressure with a competing operand held on the input
    or8 = 1'b0; iv8 = 1'b1; id8 = 8'h53;
    @(posedge clk_sys); @(negedge clk_sys);
    id8 = 8'h07;
    vcnt = 0;
    while (!ov8 && vcnt < 50) begin @(negedge clk_sys); vcnt++; end
    chk("bp_first", int'(od8), 'hCA);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      chk("bp_hold", int'(od8), 'hCA);
      chk("bp_valid", int'(ov8), 1);
      chk("bp_in_ready", int'(ir8), 0);
    end
    or8 = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    chk("bp_release_valid", int'(ov8), 0);
    chk("bp_release_ready", int'(ir8), 1);
    @(posedge clk_sys); @(negedge clk_sys);
    iv8 = 1'b0;
    vcnt = 0;
    while (!ov8 && vcnt < 50) begin @(negedge clk_sys); vcnt++; end
    chk("bp_second", int'(od8), finv('h07, 8, 'h11B));
    @(posedge clk_sys); @(negedge clk_sys);

    // Reset in the middle of a calculation
    or8 = 1'b1; iv8 = 1'b1; id8 = 8'h53;
    @(posedge clk_sys); @(negedge clk_sys);
    iv8 = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_b = 1'b0;
    #1;
    chk("midrst_in_ready_low", int'(ir8), 0);
    @(posedge clk_sys); @(negedge clk_sys);
    chk("midrst_valid", int'(ov8), 0);
    rst_b = 1'b1;
    #1;
    chk("midrst_in_ready", int'(ir8), 1);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      if (ov8) vcnt++;
    end
    chk("midrst_no_output", vcnt, 0);
    do_op(1'b0, 'h02, 0, r, lat);
    chk("midrst_next", r, 'h8D);

    // Back-to-back with in_valid held high
    or8 = 1'b1; iv8 = 1'b1; id8 = 8'h53;
    @(posedge clk_sys); @(negedge clk_sys);
    id8 = 8'h02;
    nres = 0;
    res_w = '{0, 0};
    res_d = '{0, 0};
    for (int w = 0; w < 40 && nres < 2; w++) begin
      if (ov8) begin
        res_w[nres] = w;
        res_d[nres] = int'(od8);
        nres++;
        if (nres == 2) iv8 = 1'b0;
      end
      if (nres < 2) @(negedge clk_sys);
    end
    iv8 = 1'b0;
    chk("b2b_count", nres, 2);
    chk("b2b_first", res_d[0], 'hCA);
    chk("b2b_second", res_d[1], 'h8D);
    chk("b2b_first_lat", res_w[0], 7);
    chk("b2b_spacing", res_w[1] - res_w[0], 9);
    repeat (3) @(negedge clk_sys);
    chk("b2b_idle", int'(ir8), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
